accumulator_controller: RTL and testbench

// - Sequences one 5-bit ripple-carry accumulation pass: clears the accumulator,

---
 rtl/acc_ctrl_pkg.sv | 15 +
 rtl/ripple_carry_adder.sv | 26 ++
 rtl/accumulator_controller.sv | 124 ++++++++++++
 tb/tb_accumulator_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator controller: state encoding and default widths.
package acc_ctrl_pkg;

  localparam int DATA_W_DEF      = 4;
  localparam int ACC_W_DEF       = 5;
  localparam int NUM_SAMPLES_DEF = 4;

  // 2'd3 is unused; the controller treats it as IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder: SUM = A + zero-extended B, modulo 2^ACC_W.
module ripple_carry_adder #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 5
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o
);

  logic [ACC_W-1:0] b_ext;
  logic             carry;

  assign b_ext = ACC_W'(b_i);

  // The final carry is the dropped carry-out; wrap is detected by the caller.
  always_comb begin
    carry = 1'b0;
    sum_o = '0;
    for (int i = 0; i < ACC_W; i++) begin
      sum_o[i] = a_i[i] ^ b_ext[i] ^ carry;
      carry    = (a_i[i] & b_ext[i]) | (carry & (a_i[i] ^ b_ext[i]));
    end
  end

endmodule

// File: rtl/accumulator_controller.sv
// Sequences one accumulation pass of NUM_SAMPLES operands through the single adder
// and holds the result with done/overflow flags until the next start or clear.
//
// state   | meaning
// IDLE    | waiting for start; acc/count/overflow cleared
// ACCUM   | accepting operands, in_ready/busy high
// DONE    | pass complete, result frozen, done high
module accumulator_controller
  import acc_ctrl_pkg::*;
#(
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int ACC_W       = ACC_W_DEF,
  parameter  int NUM_SAMPLES = NUM_SAMPLES_DEF,
  localparam int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum_d;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             wrap;
  logic             last_xfer;

  ripple_carry_adder #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (sum_d)
  );

  assign wrap      = (sum_d < acc_q);
  assign last_xfer = (count_q == CNT_W'(NUM_SAMPLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (clear) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          // in_ready is high throughout ACCUM, so in_valid alone marks a transfer
          if (in_valid && in_ready_q) begin
            acc_q      <= sum_d;
            count_q    <= count_q + CNT_W'(1);
            overflow_q <= overflow_q | wrap;
            if (last_xfer) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_q    <= S_ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            state_q    <= S_ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end else begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign acc_out  = acc_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_accumulator_controller.sv
// Scoreboard bench: stimulus pushes expected acc/count/overflow per operand,
// a monitor pops and compares after every accepted transfer.
module tb_accumulator_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [4:0] acc_out;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic       overflow;

  typedef struct {
    int acc;
    int cnt;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  accumulator_controller dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .acc_out  (acc_out),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per accepted operand, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (in_valid && in_ready && !rst && !clear) begin
        #1;
        if (sb.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_acc", int'(acc_out), e.acc);
          check("sb_count", int'(count), e.cnt);
          check("sb_overflow", int'(overflow), e.ovf);
        end
      end
    end
  end

  task automatic send(input int d, input int eacc, input int ecnt, input int eovf);
    exp_t e;
    e.acc = eacc;
    e.cnt = ecnt;
    e.ovf = eovf;
    in_valid = 1'b1;
    in_data  = 4'(d);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_input();
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  initial begin
    int stall_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int stall_n;
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 4'd0;
    #3;
    check("rst_acc", int'(acc_out), 0);
    check("rst_count", int'(count), 0);
    check("rst_flags", {in_ready, busy, done, overflow}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_data = 4'd7;
    @(negedge clk); @(negedge clk);
    check("idle_acc", int'(acc_out), 0);
    check("idle_ready", int'(in_ready), 0);
    check("idle_busy", int'(busy), 0);
    idle_input();

    // basic pass
    pulse_start();
    check("start_busy", int'(busy), 1);
    check("start_ready", int'(in_ready), 1);
    check("start_done", int'(done), 0);
    send(3, 3, 1, 0);
    send(5, 8, 2, 0);
    send(7, 15, 3, 0);
    send(9, 24, 4, 0);
    idle_input();
    check("basic_done", int'(done), 1);
    check("basic_busy", int'(busy), 0);
    check("basic_ready", int'(in_ready), 0);
    check("basic_count", int'(count), 4);
    check("basic_acc", int'(acc_out), 24);
    check("basic_ovf", int'(overflow), 0);
    in_valid = 1'b1; in_data = 4'd6;
    @(negedge clk);
    idle_input();
    check("done_frozen_acc", int'(acc_out), 24);
    check("done_held", int'(done), 1);

    // start from DONE: overflow pass
    pulse_start();
    check("restart_acc", int'(acc_out), 0);
    check("restart_count", int'(count), 0);
    check("restart_done", int'(done), 0);
    send(15, 15, 1, 0);
    send(15, 30, 2, 0);
    send(15, 13, 3, 1);
    send(1, 14, 4, 1);
    idle_input();
    @(negedge clk);
    check("ovf_done", int'(done), 1);
    check("ovf_sticky", int'(overflow), 1);
    check("ovf_acc", int'(acc_out), 14);

    // stalls
    pulse_start();
    stall_n = 0;
    foreach (stall_pat[i]) begin
      check("stall_ready", int'(in_ready), 1);
      if (stall_pat[i] == 1) begin
        stall_n++;
        send(2, 2 * stall_n, stall_n, 0);
      end else begin
        in_valid = 1'b0; in_data = 4'd2;
        @(negedge clk);
      end
    end
    idle_input();
    check("stall_acc", int'(acc_out), 8);
    check("stall_done", int'(done), 1);

    // start ignored mid-ACCUM
    pulse_start();
    send(1, 1, 1, 0);
    send(2, 3, 2, 0);
    idle_input();
    pulse_start();
    check("midstart_count", int'(count), 2);
    check("midstart_acc", int'(acc_out), 3);
    check("midstart_busy", int'(busy), 1);
    send(3, 6, 3, 0);
    send(4, 10, 4, 0);
    idle_input();
    check("midstart_done", int'(done), 1);

    // clear mid-pass
    pulse_start();
    send(4, 4, 1, 0);
    send(4, 8, 2, 0);
    idle_input();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_acc", int'(acc_out), 0);
    check("clear_count", int'(count), 0);
    check("clear_busy", int'(busy), 0);
    check("clear_ready", int'(in_ready), 0);

    // start+clear in DONE -> IDLE
    pulse_start();
    send(1, 1, 1, 0);
    send(1, 2, 2, 0);
    send(1, 3, 3, 0);
    send(1, 4, 4, 0);
    idle_input();
    check("pre_clear_done", int'(done), 1);
    start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("sc_done", int'(done), 0);
    check("sc_busy", int'(busy), 0);
    check("sc_acc", int'(acc_out), 0);

    // async reset mid-pass
    pulse_start();
    send(15, 15, 1, 0);
    send(15, 30, 2, 0);
    send(15, 13, 3, 1);
    idle_input();
    #2;
    rst = 1'b1;
    #1;
    check("arst_acc", int'(acc_out), 0);
    check("arst_count", int'(count), 0);
    check("arst_flags", {in_ready, busy, done, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    pulse_start();
    send(1, 1, 1, 0);
    send(1, 2, 2, 0);
    send(1, 3, 3, 0);
    send(1, 4, 4, 0);
    idle_input();
    check("post_rst_acc", int'(acc_out), 4);
    check("post_rst_done", int'(done), 1);

    @(negedge clk); @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
